sipo_deserializer: RTL and testbench
====================================

# sipo_deserializer

Serial-in, parallel-out receiver that reassembles the framed bit stream produced by the team's parallel-in/serial-out shift register into WIDTH-bit words. It sits at the receive end of the serial link: bits arrive one per qualified clock, a frame strobe marks the first bit of each word, and completed words are presented on a valid/ready output port. Partial words interrupted by a new frame and completed words the consumer cannot accept are reported on error pulses.

## Interface
- WIDTH, 4: word length in bits; legal range 2..32.
- MSB_FIRST, 1: 1 means the first received bit lands in pout[WIDTH-1]; 0 means it lands in pout[0].

- clk  input  1  rising-edge clock; single clock domain.
- reset  input  1  asynchronous, active-high reset.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin is sampled only when high.
- frame  input  1  qualified by sin_valid; marks sin as bit 0 of a new word.
- pout  output  WIDTH  assembled word; stable while pout_valid is high.
- pout_valid  output  1  word available.
- out_ready  input  1  consumer accepts pout when high with pout_valid.
- busy  output  1  high while a partial word is held (state SHIFT).
- overrun  output  1  one-cycle pulse: a completed word was dropped.
- frame_err  output  1  one-cycle pulse: a partial word was discarded by a new frame.

## Operation
- Registers: shift register sh[WIDTH-1:0], bit counter cnt (clog2(WIDTH+1) bits), output register pout plus pout_valid, 2-state FSM {IDLE, SHIFT}.
- Bit insertion: MSB_FIRST=1 gives sh <= {sh[WIDTH-2:0], sin}; MSB_FIRST=0 gives sh <= {sin, sh[WIDTH-1:1]}.
- IDLE:
  - sin_valid && frame: load the first bit into a cleared sh, cnt <= 1, go to SHIFT.
  - sin_valid && !frame: ignore the bit; no flag is raised.
- SHIFT with sin_valid && !frame:
  - insert the bit, cnt <= cnt+1.
  - When this is bit WIDTH (cnt == WIDTH-1 before the edge), the word completes: go to IDLE, cnt <= 0.
- SHIFT with sin_valid && frame:
  - discard the partial word and pulse frame_err.
  - Restart with this bit as bit 0 (cnt <= 1); stay in SHIFT.
- SHIFT with !sin_valid: hold all state; no timeout.
- Word completion transfer:
  - If pout_valid==0, or pout_valid && out_ready in the same cycle, then pout <= assembled word (including the final bit) and pout_valid <= 1.
  - Otherwise drop the word, pulse overrun, and leave pout/pout_valid unchanged.
- Output handshake: pout_valid && out_ready with no completion in that cycle gives pout_valid <= 0. pout keeps its last value.
- busy = (state == SHIFT).
- Reset (asynchronous, any time, including mid-word): state IDLE, sh=0, cnt=0, pout=0, pout_valid=0, overrun=0, frame_err=0, busy=0. A partial word is lost silently.

## Timing
- Latency: the final bit is sampled at edge t; pout/pout_valid are updated at that same edge and are visible in cycle t+1.
- Back-to-back words are supported:
  - The completing edge returns the FSM to IDLE, so a frame in the very next cycle is accepted.
  - Sustained throughput is one bit per clock with no gap cycles.
- A word of WIDTH bits needs at least WIDTH qualified cycles; gaps in sin_valid only stretch it.
- overrun and frame_err are registered and high for exactly one cycle after the causing edge. They are never high in the same cycle, because completion and restart are mutually exclusive.
- out_ready is ignored while pout_valid==0.

## Test plan
- Basic MSB-first, WIDTH=4: frame+sin=1, then 0,1,1 on consecutive cycles with out_ready=1 -> pout=4'b1011 with pout_valid high for one cycle starting the cycle after the 4th bit; busy high for cycles 2-4.
- Back-to-back with gaps: 1011 then immediately 1001, with sin_valid dropped for 2 cycles inside the second word -> pout=1011 then pout=1001, each valid one cycle; no error pulses.
- Overrun: out_ready=0; send 1011 then 0110 -> pout stays 1011 with pout_valid held, overrun pulses once after 0110's last bit; raising out_ready then drops pout_valid.
- Simultaneous drain and complete: pout_valid=1 (1011) with out_ready=1 on the cycle 1001 completes -> pout=1001, pout_valid stays 1, no overrun.
- Re-frame and stray bits: sin_valid bits without frame in IDLE -> ignored; frame, 1, 1, then frame on the third bit followed by 0,0,1 -> frame_err pulse, then pout=4'b0001 (new-frame bit 0 plus three bits).
- Reset mid-word and LSB-first: assert reset after 2 bits -> all outputs 0 immediately; with MSB_FIRST=0, serial 1,1,0,1 -> pout=4'b1011.

Source files
------------

// File: rtl/sipo_deserializer.sv
// ============================================================================
// Module   : sipo_deserializer
// Brief    : Framed serial-in/parallel-out receiver with valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sipo_deserializer #(
   parameter int WIDTH     = 4,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sin,
   input  logic             sin_valid,
   input  logic             frame,
   output logic [WIDTH-1:0] pout,
   output logic             pout_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             overrun,
   output logic             frame_err
);

   localparam int            CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] pout_q, pout_d;
   logic             pout_valid_q, pout_valid_d;
   logic             overrun_q, overrun_d;
   logic             frame_err_q, frame_err_d;
   logic             complete;

   function automatic logic [WIDTH-1:0] insert_bit(input logic [WIDTH-1:0] cur,
                                                   input logic             b);
      if (MSB_FIRST != 0) return {cur[WIDTH-2:0], b};
      else                return {b, cur[WIDTH-1:1]};
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         sh_q         <= '0;
         cnt_q        <= '0;
         pout_q       <= '0;
         pout_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         sh_q         <= sh_d;
         cnt_q        <= cnt_d;
         pout_q       <= pout_d;
         pout_valid_q <= pout_valid_d;
         overrun_q    <= overrun_d;
         frame_err_q  <= frame_err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      sh_d         = sh_q;
      cnt_d        = cnt_q;
      pout_d       = pout_q;
      pout_valid_d = pout_valid_q;
      overrun_d    = 1'b0;
      frame_err_d  = 1'b0;
      complete     = 1'b0;

      case (state_q)
         IDLE: begin
            // Bits outside a frame are stray and silently ignored.
            if (sin_valid && frame) begin
               sh_d    = insert_bit('0, sin);
               cnt_d   = CW'(1);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (sin_valid) begin
               if (frame) begin
                  sh_d        = insert_bit('0, sin);
                  cnt_d       = CW'(1);
                  frame_err_d = 1'b1;
               end else begin
                  sh_d = insert_bit(sh_q, sin);
                  if (cnt_q == LAST) begin
                     cnt_d    = '0;
                     state_d  = IDLE;
                     complete = 1'b1;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A completing word may replace one being drained in the same cycle.
      if (complete) begin
         if (!pout_valid_q || out_ready) begin
            pout_d       = sh_d;
            pout_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (pout_valid_q && out_ready) begin
         pout_valid_d = 1'b0;
      end
   end

   assign pout       = pout_q;
   assign pout_valid = pout_valid_q;
   assign busy       = (state_q == SHIFT);
   assign overrun    = overrun_q;
   assign frame_err  = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: fixed vectors, corner sequences and random
// traffic against a frame-level model, for both bit orders.
`default_nettype none

module tb_sipo_deserializer;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         sin = 1'b0, sin_valid = 1'b0, frame = 1'b0, out_ready = 1'b0;
   logic [W-1:0] pout_m, pout_l;
   logic         pv_m, pv_l, busy_m, busy_l, ovr_m, ovr_l, ferr_m, ferr_l;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1)) u_m (
      .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .frame(frame),
      .pout(pout_m), .pout_valid(pv_m), .out_ready(out_ready), .busy(busy_m),
      .overrun(ovr_m), .frame_err(ferr_m));

   sipo_deserializer #(.WIDTH(W), .MSB_FIRST(0)) u_l (
      .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .frame(frame),
      .pout(pout_l), .pout_valid(pv_l), .out_ready(out_ready), .busy(busy_l),
      .overrun(ovr_l), .frame_err(ferr_l));

   // Reference model: collects the bits of the current frame in a queue.
   bit           cur[$];
   bit           m_active;
   logic [W-1:0] m_pout_m, m_pout_l;
   bit           m_pv, m_ovr, m_ferr;

   task automatic model_reset();
      cur.delete();
      m_active = 0; m_pout_m = '0; m_pout_l = '0;
      m_pv = 0; m_ovr = 0; m_ferr = 0;
   endtask

   task automatic model_edge(input bit sv, input bit fr, input bit s, input bit rdy);
      bit done;
      done   = 0;
      m_ferr = 0;
      m_ovr  = 0;
      if (sv) begin
         if (fr) begin
            if (m_active) m_ferr = 1;
            cur.delete();
            cur.push_back(s);
            m_active = 1;
         end else if (m_active) begin
            cur.push_back(s);
            if (cur.size() == W) begin
               done = 1;
               m_active = 0;
            end
         end
      end
      if (done) begin
         if (!m_pv || rdy) begin
            for (int i = 0; i < W; i++) begin
               m_pout_m[W-1-i] = cur[i];
               m_pout_l[i]     = cur[i];
            end
            m_pv = 1;
         end else begin
            m_ovr = 1;
         end
      end else if (m_pv && rdy) begin
         m_pv = 0;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_model();
      chk("m.pout", 32'(pout_m), 32'(m_pout_m));
      chk("l.pout", 32'(pout_l), 32'(m_pout_l));
      chk("m.pv", 32'(pv_m), 32'(m_pv));
      chk("l.pv", 32'(pv_l), 32'(m_pv));
      chk("m.busy", 32'(busy_m), 32'(m_active));
      chk("l.busy", 32'(busy_l), 32'(m_active));
      chk("m.ovr", 32'(ovr_m), 32'(m_ovr));
      chk("l.ovr", 32'(ovr_l), 32'(m_ovr));
      chk("m.ferr", 32'(ferr_m), 32'(m_ferr));
      chk("l.ferr", 32'(ferr_l), 32'(m_ferr));
   endtask

   // Apply inputs for one edge, advance the model, compare 1 time unit later.
   task automatic step(input bit sv, input bit fr, input bit s, input bit rdy);
      sin_valid = sv; frame = fr; sin = s; out_ready = rdy;
      @(posedge clk);
      model_edge(sv, fr, s, rdy);
      #1;
      chk_model();
   endtask

   typedef struct {
      bit           sv, fr, s, rdy;
      logic [W-1:0] pout;
      bit           pv, busy, ovr, ferr;
   } vec_t;

   vec_t vecs[30];

   initial begin
      // Basic 1011, then 1001 with a two-cycle gap.
      vecs[0]  = '{1,1,1,1, 4'h0,0,1,0,0};
      vecs[1]  = '{1,0,0,1, 4'h0,0,1,0,0};
      vecs[2]  = '{1,0,1,1, 4'h0,0,1,0,0};
      vecs[3]  = '{1,0,1,1, 4'hB,1,0,0,0};
      vecs[4]  = '{1,1,1,1, 4'hB,0,1,0,0};
      vecs[5]  = '{1,0,0,1, 4'hB,0,1,0,0};
      vecs[6]  = '{0,0,0,1, 4'hB,0,1,0,0};
      vecs[7]  = '{0,0,1,1, 4'hB,0,1,0,0};
      vecs[8]  = '{1,0,0,1, 4'hB,0,1,0,0};
      vecs[9]  = '{1,0,1,1, 4'h9,1,0,0,0};
      vecs[10] = '{0,0,0,1, 4'h9,0,0,0,0};
      // Overrun: 1011 held, 0110 dropped.
      vecs[11] = '{1,1,1,0, 4'h9,0,1,0,0};
      vecs[12] = '{1,0,0,0, 4'h9,0,1,0,0};
      vecs[13] = '{1,0,1,0, 4'h9,0,1,0,0};
      vecs[14] = '{1,0,1,0, 4'hB,1,0,0,0};
      vecs[15] = '{1,1,0,0, 4'hB,1,1,0,0};
      vecs[16] = '{1,0,1,0, 4'hB,1,1,0,0};
      vecs[17] = '{1,0,1,0, 4'hB,1,1,0,0};
      vecs[18] = '{1,0,0,0, 4'hB,1,0,1,0};
      vecs[19] = '{0,0,0,0, 4'hB,1,0,0,0};
      vecs[20] = '{0,0,0,1, 4'hB,0,0,0,0};
      // Drain and complete in the same cycle.
      vecs[21] = '{1,1,1,0, 4'hB,0,1,0,0};
      vecs[22] = '{1,0,0,0, 4'hB,0,1,0,0};
      vecs[23] = '{1,0,1,0, 4'hB,0,1,0,0};
      vecs[24] = '{1,0,1,0, 4'hB,1,0,0,0};
      vecs[25] = '{1,1,1,0, 4'hB,1,1,0,0};
      vecs[26] = '{1,0,0,0, 4'hB,1,1,0,0};
      vecs[27] = '{1,0,0,0, 4'hB,1,1,0,0};
      vecs[28] = '{1,0,1,1, 4'h9,1,0,0,0};
      vecs[29] = '{0,0,0,1, 4'h9,0,0,0,0};

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst.pout", 32'(pout_m), 32'h0);
      chk("rst.pv", 32'(pv_m), 32'h0);
      chk("rst.busy", 32'(busy_m), 32'h0);
      chk("rst.flags", 32'({ovr_m, ferr_m}), 32'h0);
      reset = 1'b0;

      for (int i = 0; i < 30; i++) begin
         step(vecs[i].sv, vecs[i].fr, vecs[i].s, vecs[i].rdy);
         chk($sformatf("vec%0d.pout", i), 32'(pout_m), 32'(vecs[i].pout));
         chk($sformatf("vec%0d.pv", i), 32'(pv_m), 32'(vecs[i].pv));
         chk($sformatf("vec%0d.busy", i), 32'(busy_m), 32'(vecs[i].busy));
         chk($sformatf("vec%0d.ovr", i), 32'(ovr_m), 32'(vecs[i].ovr));
         chk($sformatf("vec%0d.ferr", i), 32'(ferr_m), 32'(vecs[i].ferr));
      end

      // Stray bits in IDLE, then a re-frame after two bits.
      step(1, 0, 1, 1);
      step(1, 0, 1, 1);
      chk("stray.busy", 32'(busy_m), 32'h0);
      step(1, 1, 1, 1);
      step(1, 0, 1, 1);
      step(1, 1, 0, 1);
      chk("reframe.ferr", 32'(ferr_m), 32'h1);
      chk("reframe.busy", 32'(busy_m), 32'h1);
      step(1, 0, 0, 1);
      chk("reframe.ferr_once", 32'(ferr_m), 32'h0);
      step(1, 0, 0, 1);
      step(1, 0, 1, 1);
      chk("reframe.pout", 32'(pout_m), 32'h1);
      chk("reframe.pv", 32'(pv_m), 32'h1);

      // Asynchronous reset after two bits of a word.
      step(1, 1, 1, 0);
      step(1, 0, 1, 0);
      reset = 1'b1;
      #1;
      model_reset();
      chk("amid.pout", 32'({pout_m, pout_l}), 32'h0);
      chk("amid.pv", 32'({pv_m, pv_l}), 32'h0);
      chk("amid.busy", 32'({busy_m, busy_l}), 32'h0);
      #2;
      reset = 1'b0;

      // LSB-first order.
      step(1, 1, 1, 1);
      step(1, 0, 1, 1);
      step(1, 0, 0, 1);
      step(1, 0, 1, 1);
      chk("lsb.pout", 32'(pout_l), 32'hB);
      chk("lsb.pv", 32'(pv_l), 32'h1);

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2,
              1'($urandom), $urandom_range(0, 1) == 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
